// File: rtl/yuv_frame_sequencer.sv
// Tags a raw 4:2:0 planar YUV byte stream (Y, Cb, Cr per frame) with plane,
// coordinates and frame/line markers through a one-deep valid/ready register.
module yuv_frame_sequencer #(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   num_frames,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic [1:0]    out_plane,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic [15:0]   frame_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, LUMA, CB, CR, DRAIN} state_t;

  localparam logic [CW-1:0] LUMA_X_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LUMA_Y_LAST   = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] CHROMA_X_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] CHROMA_Y_LAST = CW'(HEIGHT / 2 - 1);

  state_t        state, state_nx;
  logic [CW-1:0] x, y;
  logic [15:0]   frame_cnt, frames_tgt, frame_cnt_inc;
  logic          in_plane, accept, x_last, y_last, plane_last, frame_last;
  logic          run_complete;
  logic [1:0]    plane;

  // Position decode for the byte currently offered by the source.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    in_plane      = 1'b0;
    plane         = 2'd0;
    x_last        = 1'b0;
    y_last        = 1'b0;
    case (state)
      LUMA: begin
        in_plane = 1'b1;
        plane    = 2'd0;
        x_last   = (x == LUMA_X_LAST);
        y_last   = (y == LUMA_Y_LAST);
      end
      CB, CR: begin
        in_plane = 1'b1;
        plane    = (state == CB) ? 2'd1 : 2'd2;
        x_last   = (x == CHROMA_X_LAST);
        y_last   = (y == CHROMA_Y_LAST);
      end
      default: ;
    endcase
    plane_last    = x_last && y_last;
    frame_last    = (state == CR) && plane_last;
    frame_cnt_inc = frame_cnt + 16'd1;
    run_complete  = (frames_tgt != 16'd0) && (frame_cnt_inc == frames_tgt);
    in_ready      = in_plane && (!out_valid || out_ready);
    accept        = in_valid && in_ready;
    busy          = (state != IDLE);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LUMA;
      LUMA:    if (accept && plane_last) state_nx = CB;
      CB:      if (accept && plane_last) state_nx = CR;
      CR:      if (accept && plane_last) state_nx = run_complete ? DRAIN : LUMA;
      DRAIN:   if (!out_valid || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == DRAIN) && (!out_valid || out_ready);
    end
  end

  // Raster counters move only on an accepted byte; start rearms the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      frame_cnt  <= '0;
      frames_tgt <= '0;
    end else if (state == IDLE && start) begin
      x          <= '0;
      y          <= '0;
      frame_cnt  <= '0;
      frames_tgt <= num_frames;
    end else if (accept) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
      if (frame_last) frame_cnt <= frame_cnt_inc;
    end
  end

  // One-deep output register; contents hold while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_plane <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      frame_idx <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_plane <= plane;
      out_x     <= x;
      out_y     <= y;
      out_sof   <= (state == LUMA) && (x == '0) && (y == '0);
      out_eol   <= x_last;
      out_eof   <= frame_last;
      frame_idx <= frame_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_yuv_frame_sequencer.sv
// Self-checking bench: table-driven directed runs plus randomized runs
// scored against a frame-layout model computed from byte index arithmetic.
module tb_yuv_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CW = 4;
  localparam int FS = W * H * 3 / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   num_frames = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    out_plane;
  logic [CW-1:0] out_x, out_y;
  logic          out_sof, out_eol, out_eof;
  logic [15:0]   frame_idx;
  logic          busy, done;

  yuv_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_plane(out_plane), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_idx(frame_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    int         plane, x, y;
    bit         sof, eol, eof;
  } vec_t;

  vec_t       tbl [FS];
  logic [7:0] sb [$];
  logic [7:0] next_byte;
  logic [63:0] snap;
  bit         use_table, stalled;
  int         checks = 0, fails = 0;
  int         cyc, rx_cnt, tx_cnt, done_cnt, done_cyc, last_rx_cyc;
  int         sof_cnt, eof_cnt, last_fidx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack(input logic [7:0] d, input int p, input int x,
                                       input int y, input bit sof, input bit eol,
                                       input bit eof, input int fr);
    return {13'd0, d, 2'(p), 11'(x), 11'(y), sof, eol, eof, 16'(fr)};
  endfunction

  // Frame layout from byte index: Y plane, then Cb, then Cr, FS bytes per frame.
  function automatic logic [63:0] model_tag(input logic [7:0] d, input int k);
    int fr, off, p, pw, ph, x, y;
    fr  = k / FS;
    off = k % FS;
    if (off < W * H) begin
      p = 0; pw = W; ph = H;
    end else if (off < W * H * 5 / 4) begin
      p = 1; pw = W / 2; ph = H / 2; off = off - W * H;
    end else begin
      p = 2; pw = W / 2; ph = H / 2; off = off - W * H * 5 / 4;
    end
    x = off % pw;
    y = off / pw;
    return pack(d, p, x, y, (p == 0) && (off == 0), x == pw - 1,
                (p == 2) && (off == pw * ph - 1), fr);
  endfunction

  task automatic begin_run(input bit tbl_mode, input logic [15:0] nf);
    sb.delete();
    use_table = tbl_mode;
    stalled = 0;
    rx_cnt = 0; tx_cnt = 0; done_cnt = 0; done_cyc = -1; last_rx_cyc = -1;
    sof_cnt = 0; eof_cnt = 0; last_fidx = -1;
    num_frames = nf;
    next_byte = tbl_mode ? tbl[0].din : 8'($urandom);
  endtask

  // One clock: drive at negedge, then score handshakes that complete at the next posedge.
  task automatic cycle(input bit st, input bit iv, input bit ordy);
    logic [63:0] act, exp;
    logic [7:0]  exp_d;
    @(negedge clk);
    start = st; in_valid = iv; out_ready = ordy; in_data = next_byte;
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    act = pack(out_data, out_plane, out_x, out_y, out_sof, out_eol, out_eof, frame_idx);
    if (stalled) begin
      act[63] = out_valid;
      check("stall_hold", act, {1'b1, snap[62:0]});
      act[63] = 1'b0;
    end
    stalled = out_valid && !ordy;
    if (stalled) snap = act;
    if (out_valid && ordy) begin
      if (sb.size() == 0) begin
        check("unexpected_out", act, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_d = sb.pop_front();
        if (use_table) begin
          if (rx_cnt < FS)
            exp = pack(tbl[rx_cnt].din, tbl[rx_cnt].plane, tbl[rx_cnt].x, tbl[rx_cnt].y,
                       tbl[rx_cnt].sof, tbl[rx_cnt].eol, tbl[rx_cnt].eof, 0);
          else
            exp = 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
          exp = model_tag(exp_d, rx_cnt);
        end
        check("out_tags", act, exp);
      end
      sof_cnt += int'(out_sof);
      eof_cnt += int'(out_eof);
      last_fidx = int'(frame_idx);
      rx_cnt++;
      last_rx_cyc = cyc;
    end
    if (iv && in_ready) begin
      sb.push_back(next_byte);
      tx_cnt++;
      if (use_table) next_byte = (tx_cnt < FS) ? tbl[tx_cnt].din : 8'hEE;
      else           next_byte = 8'($urandom);
    end
  endtask

  task automatic check_idle_after_run(input string tag, input int bytes);
    check({tag, "_rx"}, 64'(rx_cnt), 64'(bytes));
    check({tag, "_tx"}, 64'(tx_cnt), 64'(bytes));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_timing"}, 64'(done_cyc), 64'(last_rx_cyc + 1));
    check({tag, "_idle"}, {62'd0, in_ready, busy}, 64'd0);
  endtask

  // Directed 4x2 single-frame run; throttle lets the sink accept 1 cycle in 3
  // and pulses start mid-run with a different frame count.
  task automatic run_directed(input bit throttle);
    begin_run(1'b1, 16'd1);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      if (throttle && i == 10) num_frames = 16'd7;
      cycle(throttle && i == 10, 1'b1, throttle ? (i % 3 == 2) : 1'b1);
    end
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    check_idle_after_run(throttle ? "dir_throttle" : "dir_full", FS);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_tags", pack(out_data, out_plane, out_x, out_y, out_sof, out_eol, out_eof,
                             frame_idx), 64'd0);
    check("reset_ctl", {60'd0, out_valid, in_ready, busy, done}, 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0;
    tbl[0]  = '{8'd0,  0, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{8'd1,  0, 1, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'd2,  0, 2, 0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'd3,  0, 3, 0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{8'd4,  0, 0, 1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'd5,  0, 1, 1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'd6,  0, 2, 1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'd7,  0, 3, 1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8'd8,  1, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'd9,  1, 1, 0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{8'd10, 2, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{8'd11, 2, 1, 0, 1'b0, 1'b1, 1'b1};

    do_reset();
    run_directed(1'b0);
    run_directed(1'b1);

    // Three frames with random source gaps and sink stalls.
    begin_run(1'b0, 16'd3);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3000 && done_cnt == 0; i++)
      cycle(1'b0, ($urandom % 4) != 0, ($urandom % 4) != 0);
    repeat (5) cycle(1'b0, 1'b1, 1'b1);
    check_idle_after_run("rand3", 3 * FS);
    check("rand3_sof_cnt", 64'(sof_cnt), 64'd3);
    check("rand3_eof_cnt", 64'(eof_cnt), 64'd3);
    check("rand3_last_frame", 64'(last_fidx), 64'd2);

    // Unlimited mode: 40 bytes runs into the fourth frame without finishing.
    begin_run(1'b0, 16'd0);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 1000 && tx_cnt < 40; i++)
      cycle(1'b0, ($urandom % 3) != 0, ($urandom % 3) != 0);
    for (int i = 0; i < 100 && rx_cnt < 40; i++)
      cycle(1'b0, 1'b0, 1'b1);
    check("unl_rx", 64'(rx_cnt), 64'd40);
    check("unl_tx", 64'(tx_cnt), 64'd40);
    check("unl_last_frame", 64'(last_fidx), 64'd3);
    check("unl_no_done", 64'(done_cnt), 64'd0);
    check("unl_busy", 64'(busy), 64'd1);

    // Reset with a Cb byte held in the output register, then a clean restart.
    do_reset();
    begin_run(1'b1, 16'd1);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      cycle(1'b0, tx_cnt < 9, rx_cnt < 8);
    check("pre_rst_held_cb", {62'd0, out_valid, out_plane == 2'd1}, 64'd3);
    #2 rst = 1'b1;
    #1;
    check("midrst_ctl", {61'd0, out_valid, busy, in_ready}, 64'd0);
    check("midrst_tags", pack(out_data, out_plane, out_x, out_y, out_sof, out_eol, out_eof,
                              frame_idx), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_directed(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/yuv_frame_sequencer.md
Name: yuv_frame_sequencer

Overview:
- Sequences the raw 8-bit 4:2:0 planar YUV byte stream (Y plane, then Cb plane, then Cr plane, per frame) from the file-reader source into the encoder front end.
- Tags each byte with plane, x/y coordinate and frame/line markers.
- Counts frames and stops after a programmed frame count.
- Registered single-stage valid/ready pipeline between the byte source and downstream block loaders.

Parameters:
- WIDTH, 352, luma width in pixels; even, >= 2.
- HEIGHT, 288, luma height in lines; even, >= 2.
- CW, 11, coordinate counter width; 2^CW > WIDTH and 2^CW > HEIGHT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  1-cycle pulse; starts a run when idle.
- num_frames  in  16  frames per run, sampled on accepted start; 0 = unlimited.
- in_valid  in  1  source byte valid.
- in_data  in  8  source byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  tagged byte valid.
- out_data  out  8  byte.
- out_ready  in  1  downstream accept.
- out_plane  out  2  0=Y, 1=Cb, 2=Cr.
- out_x  out  CW  column within plane.
- out_y  out  CW  line within plane.
- out_sof  out  1  first byte of frame (Y 0,0).
- out_eol  out  1  last byte of a plane line.
- out_eof  out  1  last byte of frame (Cr, last position).
- frame_idx  out  16  index of the frame being output.
- busy  out  1  state != IDLE.
- done  out  1  1-cycle pulse at end of run.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. Reset mid-run aborts immediately, and the held output byte is discarded.
- States: IDLE, LUMA, CB, CR, DRAIN.
- IDLE:
  - in_ready = 0.
  - start goes to LUMA: latch num_frames, clear x, y and frame counter.
  - start in any other state is ignored.
- Handshake:
  - Output register holds one byte.
  - In LUMA/CB/CR: in_ready = !out_valid || out_ready.
  - On accept, the register loads in_data plus tags for the current position; out_valid = 1 the next cycle. Latency is 1 cycle.
  - out_valid drops when out_ready && no new accept.
  - Register contents are stable while out_valid && !out_ready.
  - Source stall (in_valid = 0) leaves counters unchanged.
- Position counters advance only on accept.
- Plane extents: LUMA uses WIDTH x HEIGHT; CB and CR use WIDTH/2 x HEIGHT/2.
- Raster order: x increments; at x = planeW-1 the byte is tagged out_eol, x wraps to 0 and y increments.
- At the last position of a plane, x and y clear and the state moves LUMA→CB→CR.
- Last Cr byte is tagged out_eof, then:
  - Frame counter increments (16-bit wrap when unlimited).
  - If num_frames != 0 and the incremented count == num_frames: go to DRAIN.
  - Otherwise go to LUMA.
- frame_idx: tags carry the frame index at accept time; the frame_idx port shows out_valid data's frame.
- DRAIN:
  - in_ready = 0.
  - Wait until the output register empties (out_valid && out_ready, or already empty).
  - Then pulse done for 1 cycle and go to IDLE in the same cycle.
- Unlimited mode exits only by reset.
- Bytes beyond the last frame are never accepted.
- Simultaneous output handoff and new accept in the same cycle is sustained at 1 byte/cycle (full throughput).

Test Plan:
- WIDTH=4, HEIGHT=2, start with num_frames=1, source and sink always ready, bytes 0..11 -> exactly 12 outputs.
  - Bytes 0-7: plane 0, with (x,y) raster order.
  - Bytes 8-9: plane 1. Bytes 10-11: plane 2.
  - out_sof on byte 0; out_eol on bytes 3,7,9,11; out_eof on byte 11.
  - done 1 cycle after byte 11 is accepted downstream; in_ready=0 afterwards.
- Same config, out_ready toggled 1-of-3 cycles -> same 12 tagged bytes in order, no duplicate or drop, tags stable while stalled.
- num_frames=3, CIF defaults, random in_valid gaps -> 152064 bytes per frame; frame_idx 0,1,2; three out_sof and three out_eof; single done; in_ready=0 thereafter.
- num_frames=0, WIDTH=4, HEIGHT=2, 40 bytes fed -> frame_idx reaches 3; done never asserts; busy stays 1.
- rst asserted mid-CB plane with out_valid=1 -> out_valid, busy and counters 0 immediately; a new start restarts at Y (0,0) with out_sof and frame_idx=0.
- start pulsed while busy -> ignored; run length and num_frames unchanged.
